// File: rtl/ex_mdu.sv
// ex_mdu: multi-cycle multiply/divide unit in the master EX slot.
// It takes operands from ID/EX, stalls the front end while it iterates and
// returns a 2*WIDTH {hi,lo} result for the HI/LO write.
// Build option MDU_FAST_MULT_EN: MULT/MULTU use a single-cycle combinational
// product and go from IDLE straight to DONE. Without it, multiply is an
// iterative shift-add with the same latency as divide.
//
// state | meaning
// IDLE  | waiting for start; latches magnitudes and sign info
// MUL   | one shift-add step per cycle
// DIV   | one restoring shift-subtract step per cycle
// DONE  | hi/lo valid, done high; waits for ex_advance
module ex_mdu #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ex_advance,
  output logic             stall,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic             neg_q;     // negate product / quotient
  logic             neg_r;     // negate remainder (sign of dividend)
  logic             div0_q;    // divisor was zero
  logic [WIDTH-1:0] opnd_q;    // multiplicand or divisor magnitude
  logic [WIDTH-1:0] acc_hi_q;  // upper product / partial remainder
  logic [WIDTH-1:0] acc_lo_q;  // multiplier->lower product / dividend->quotient
  logic [WIDTH-1:0] hi_q, lo_q;
  logic             done_q;

  // operand decode
  logic             op_is_mul;
  logic             op_signed;
  logic             sign_a, sign_b;
  logic [WIDTH-1:0] mag_a, mag_b;

  // iteration datapath
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic             div_ge;
  logic [WIDTH-1:0] nxt_hi, nxt_lo;
  logic             last_step;

  // final fix-up
  logic [2*WIDTH-1:0] prod_mag;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;

`ifdef MDU_FAST_MULT_EN
  logic signed [2*WIDTH-1:0] fast_prod_s;
  logic        [2*WIDTH-1:0] fast_prod_u;
  logic        [2*WIDTH-1:0] fast_prod;

  // Single-cycle full product from the raw operands
  always_comb begin
    fast_prod_s = $signed({{WIDTH{a[WIDTH-1]}}, a}) * $signed({{WIDTH{b[WIDTH-1]}}, b});
    fast_prod_u = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
    fast_prod   = op_signed ? fast_prod_s : fast_prod_u;
  end
`endif

  // Operand decode: op[1]=0 multiply, op[0]=1 unsigned
  always_comb begin
    op_is_mul = ~op[1];
    op_signed = ~op[0];
    sign_a    = op_signed & a[WIDTH-1];
    sign_b    = op_signed & b[WIDTH-1];
    mag_a     = sign_a ? (~a + 1'b1) : a;
    mag_b     = sign_b ? (~b + 1'b1) : b;
  end

  // One radix-2 step for the current state, plus the fixed-up result it
  // would produce if this is the last step
  always_comb begin
    mul_sum   = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
    div_shift = {acc_hi_q, acc_lo_q[WIDTH-1]};
    div_ge    = (div_shift >= {1'b0, opnd_q});
    nxt_hi    = acc_hi_q;
    nxt_lo    = acc_lo_q;
    if (state_q == S_MUL) begin
      nxt_hi = mul_sum[WIDTH:1];
      nxt_lo = {mul_sum[0], acc_lo_q[WIDTH-1:1]};
    end else if (state_q == S_DIV) begin
      // remainder stays below the divisor, so WIDTH bits hold the difference
      nxt_hi = div_ge ? (div_shift[WIDTH-1:0] - opnd_q) : div_shift[WIDTH-1:0];
      nxt_lo = {acc_lo_q[WIDTH-2:0], div_ge};
    end
    last_step = (cnt_q == CNT_W'(WIDTH-1));
    prod_mag  = {nxt_hi, nxt_lo};
    prod_fix  = neg_q ? (~prod_mag + 1'b1) : prod_mag;
    // x/0 leaves quotient all ones and remainder = |a|, which the sign
    // fix-up turns back into a; only the quotient needs forcing
    quo_fix   = div0_q ? {WIDTH{1'b1}} : (neg_q ? (~nxt_lo + 1'b1) : nxt_lo);
    rem_fix   = neg_r ? (~nxt_hi + 1'b1) : nxt_hi;
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic; flush wins over everything
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
`ifdef MDU_FAST_MULT_EN
          state_d = op_is_mul ? S_DONE : S_DIV;
`else
          state_d = op_is_mul ? S_MUL : S_DIV;
`endif
        end
      end
      S_MUL, S_DIV: begin
        if (last_step) state_d = S_DONE;
      end
      S_DONE: begin
        if (ex_advance) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (flush) state_d = S_IDLE;
  end

  // Datapath, counter and result registers
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      div0_q   <= 1'b0;
      opnd_q   <= '0;
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
    end else if (flush) begin
      done_q <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            cnt_q    <= '0;
            neg_q    <= sign_a ^ sign_b;
            neg_r    <= sign_a;
            div0_q   <= ~op_is_mul & (b == '0);
            opnd_q   <= op_is_mul ? mag_a : mag_b;
            acc_hi_q <= '0;
            acc_lo_q <= op_is_mul ? mag_b : mag_a;
`ifdef MDU_FAST_MULT_EN
            if (op_is_mul) begin
              hi_q   <= fast_prod[2*WIDTH-1:WIDTH];
              lo_q   <= fast_prod[WIDTH-1:0];
              done_q <= 1'b1;
            end
`endif
          end
        end
        S_MUL, S_DIV: begin
          acc_hi_q <= nxt_hi;
          acc_lo_q <= nxt_lo;
          cnt_q    <= cnt_q + 1'b1;
          if (last_step) begin
            done_q <= 1'b1;
            if (state_q == S_MUL) begin
              hi_q <= prod_fix[2*WIDTH-1:WIDTH];
              lo_q <= prod_fix[WIDTH-1:0];
            end else begin
              hi_q <= rem_fix;
              lo_q <= quo_fix;
            end
          end
        end
        S_DONE: begin
          if (ex_advance) done_q <= 1'b0;
        end
        default: done_q <= 1'b0;
      endcase
    end
  end

  // Front-end stall: request in IDLE or iterating, never in DONE
  always_comb begin
    stall = ~rst & ~flush &
            (((state_q == S_IDLE) & start) | (state_q == S_MUL) | (state_q == S_DIV));
  end

  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_ex_mdu.sv
// tb_ex_mdu: directed self-checking bench for ex_mdu (WIDTH=32).
module tb_ex_mdu;

  localparam int W = 32;
`ifdef MDU_FAST_MULT_EN
  localparam int LAT_MUL = 1;
  localparam int SC_MUL  = 1;
`else
  localparam int LAT_MUL = 33;
  localparam int SC_MUL  = 33;
`endif
  localparam int LAT_DIV = 33;
  localparam int SC_DIV  = 33;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         flush = 1'b0;
  logic         start = 1'b0;
  logic [1:0]   op = 2'd0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         ex_advance = 1'b1;
  logic         stall, done;
  logic [W-1:0] hi, lo;

  int checks = 0;
  int errors = 0;
  int sc, lat, seen;

  ex_mdu #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .flush(flush), .start(start), .op(op),
    .a(a), .b(b), .ex_advance(ex_advance),
    .stall(stall), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Issue an op (called at a negedge), count stall cycles and cycles to done.
  // Leaves start high; the caller decides when to drop it.
  task automatic run_op(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                        output int n_stall, output int n_lat);
    op = o; a = x; b = y; start = 1'b1;
    n_stall = 0; n_lat = -1;
    #1;
    if (stall) n_stall++;
    for (int i = 1; i <= 100; i++) begin
      @(negedge clk);
      if (done) begin
        n_lat = i;
        break;
      end
      if (stall) n_stall++;
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("reset_hi", {32'd0, hi}, 64'd0);
    check("reset_lo", {32'd0, lo}, 64'd0);
    check("reset_done", {63'd0, done}, 64'd0);
    check("reset_stall", {63'd0, stall}, 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // 1: DIVU 100/7
    run_op(2'd3, 32'd100, 32'd7, sc, lat);
    start = 1'b0;
    check("divu_lo", {32'd0, lo}, 64'd14);
    check("divu_hi", {32'd0, hi}, 64'd2);
    check("divu_stall_cycles", 64'(sc), 64'(SC_DIV));
    check("divu_latency", 64'(lat), 64'(LAT_DIV));
    @(negedge clk);
    check("divu_done_one_cycle", {63'd0, done}, 64'd0);
    check("divu_idle_stall", {63'd0, stall}, 64'd0);

    // 2: signed divide
    run_op(2'd2, 32'hFFFF_FFF9, 32'd2, sc, lat);
    start = 1'b0;
    check("div_neg_lo", {32'd0, lo}, 64'h0000_0000_FFFF_FFFD);
    check("div_neg_hi", {32'd0, hi}, 64'h0000_0000_FFFF_FFFF);
    @(negedge clk);
    run_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, sc, lat);
    start = 1'b0;
    check("div_min_lo", {32'd0, lo}, 64'h0000_0000_8000_0000);
    check("div_min_hi", {32'd0, hi}, 64'd0);
    check("div_min_latency", 64'(lat), 64'(LAT_DIV));
    @(negedge clk);

    // 3: multiply
    run_op(2'd0, 32'hFFFF_FFFD, 32'd5, sc, lat);
    start = 1'b0;
    check("mult_hilo", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFF1);
    check("mult_latency", 64'(lat), 64'(LAT_MUL));
    check("mult_stall_cycles", 64'(sc), 64'(SC_MUL));
    @(negedge clk);
    run_op(2'd1, 32'hFFFF_FFFF, 32'd2, sc, lat);
    start = 1'b0;
    check("multu_hilo", {hi, lo}, 64'h0000_0001_FFFF_FFFE);
    @(negedge clk);

    // 4: divide by zero, then hold in DONE without advance
    ex_advance = 1'b0;
    run_op(2'd3, 32'h0000_1234, 32'd0, sc, lat);
    check("div0_lo", {32'd0, lo}, 64'h0000_0000_FFFF_FFFF);
    check("div0_hi", {32'd0, hi}, 64'h0000_0000_0000_1234);
    seen = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (!done || stall || lo !== 32'hFFFF_FFFF) seen++;
    end
    check("div0_hold_done_nostall", 64'(seen), 64'd0);
    start = 1'b0; ex_advance = 1'b1;
    @(negedge clk);
    check("div0_release_done", {63'd0, done}, 64'd0);

    // 5: flush on the 10th DIV cycle
    op = 2'd3; a = 32'd50; b = 32'd3; start = 1'b1;
    repeat (10) @(negedge clk);
    check("flush_pre_stall", {63'd0, stall}, 64'd1);
    flush = 1'b1; start = 1'b0;
    #1;
    check("flush_stall_same_cycle", {63'd0, stall}, 64'd0);
    @(negedge clk);
    flush = 1'b0;
    #1;
    check("flush_idle_stall", {63'd0, stall}, 64'd0);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) seen++;
    end
    check("flush_no_done", 64'(seen), 64'd0);
    check("flush_keep_hilo", {hi, lo}, 64'h0000_1234_FFFF_FFFF);

    // flush and start together in IDLE: nothing starts
    op = 2'd3; a = 32'd50; b = 32'd3; start = 1'b1; flush = 1'b1;
    #1;
    check("flush_start_stall", {63'd0, stall}, 64'd0);
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    #1;
    check("flush_start_not_begun", {63'd0, stall}, 64'd0);
    @(negedge clk);

    // 6: reset mid-MULT
    op = 2'd0; a = 32'd7; b = 32'd9; start = 1'b1;
    repeat (5) @(negedge clk);
    rst = 1'b1; start = 1'b0;
    @(negedge clk);
    check("rst_mid_hilo", {hi, lo}, 64'd0);
    check("rst_mid_done", {63'd0, done}, 64'd0);
    check("rst_mid_stall", {63'd0, stall}, 64'd0);
    rst = 1'b0;
    @(negedge clk);
    run_op(2'd3, 32'd9, 32'd3, sc, lat);
    start = 1'b0;
    check("post_rst_divu_lo", {32'd0, lo}, 64'd3);
    check("post_rst_divu_hi", {32'd0, hi}, 64'd0);
    check("post_rst_latency", 64'(lat), 64'(LAT_DIV));
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
